// File: rtl/mem_issue_splitter.sv
// mem_issue_splitter: holds one WIDTH-slot instruction bundle and issues it as
// a sequence of in-order groups, each carrying at most MEM_PORTS load/store ops.
// A valid/ready handshake sits on both sides; a saturating counter records
// how many non-final groups were accepted by the execute stage.
module mem_issue_splitter #(
    parameter int              WIDTH     = 4,
    parameter int              OPW       = 4,
    parameter int              MEM_PORTS = 1,
    parameter logic [OPW-1:0]  LOAD_OP   = 4'b0010,
    parameter logic [OPW-1:0]  STORE_OP  = 4'b0100,
    parameter int              CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*OPW-1:0]   in_op,
    input  logic [WIDTH-1:0]       in_slot_vld,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*OPW-1:0]   out_op,
    output logic [WIDTH-1:0]       out_issue_mask,
    output logic                   out_last,
    output logic [CNT_W-1:0]       split_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] MEM_LIM = 8'(MEM_PORTS);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [WIDTH*OPW-1:0]   op_r;
    logic [WIDTH-1:0]       pending_r;
    logic [CNT_W-1:0]       split_cnt_r;

    logic [WIDTH-1:0]       mask_s;
    logic                   out_valid_s;
    logic                   out_last_s;
    logic                   in_ready_s;
    logic                   accept_s;
    logic                   fire_s;

    // True when an opcode occupies a memory port
    function automatic logic is_mem(input logic [OPW-1:0] op);
        return (op == LOAD_OP) || (op == STORE_OP);
    endfunction

    // Group formation: longest in-order prefix of pending slots within the port budget
    always_comb begin
        logic [7:0] mem_cnt_v;
        logic       stop_v;
        logic       mem_v;
        mask_s    = '0;
        mem_cnt_v = 8'd0;
        stop_v    = 1'b0;
        mem_v     = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pending_r[i] && !stop_v) begin
                mem_v = is_mem(op_r[i*OPW +: OPW]);
                if (mem_v && (mem_cnt_v == MEM_LIM)) begin
                    stop_v = 1'b1;
                end else begin
                    mask_s[i] = 1'b1;
                    if (mem_v) begin
                        mem_cnt_v = mem_cnt_v + 8'd1;
                    end else begin
                        mem_cnt_v = mem_cnt_v;
                    end
                end
            end else begin
                mask_s[i] = 1'b0;
            end
        end
    end

    // FSM outputs and handshake qualifiers
    always_comb begin
        out_valid_s = (state_r == HOLD);
        out_last_s  = out_valid_s && (mask_s == pending_r);
        fire_s      = out_valid_s && out_ready;
        in_ready_s  = (state_r == IDLE) || (fire_s && out_last_s);
        accept_s    = in_valid && in_ready_s;
    end

    // FSM next-state: a new accept always wins over retiring the last group
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && (in_slot_vld != '0)) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOLD: begin
                if (accept_s) begin
                    state_nxt_s = (in_slot_vld != '0) ? HOLD : IDLE;
                end else if (fire_s && out_last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Bundle storage: load on accept, retire issued slots on each accepted group
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r      <= '0;
            pending_r <= '0;
        end else if (accept_s) begin
            op_r      <= in_op;
            pending_r <= in_slot_vld;
        end else if (fire_s) begin
            pending_r <= pending_r & ~mask_s;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Split counter: counts accepted non-final groups, sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_cnt_r <= '0;
        end else if (fire_s && !out_last_s && (split_cnt_r != {CNT_W{1'b1}})) begin
            split_cnt_r <= split_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            split_cnt_r <= split_cnt_r;
        end
    end

    assign in_ready       = in_ready_s;
    assign out_valid      = out_valid_s;
    assign out_op         = op_r;
    assign out_issue_mask = mask_s;
    assign out_last       = out_last_s;
    assign split_cnt      = split_cnt_r;

endmodule
